// File: rtl/instr_encoder_stream_if.sv
// instr_encoder_stream_if: field-record input and encoded-word output handshakes.
interface instr_encoder_stream_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_group;
    logic [3:0]  in_ra_index;
    logic [3:0]  in_rb_index;
    logic [3:0]  in_rc_index;
    logic [3:0]  in_opcode;
    logic [15:0] in_imm_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_bad;
    modport master (
        output in_valid, in_group, in_ra_index, in_rb_index, in_rc_index, in_opcode, in_imm_val, out_ready,
        input  in_ready, out_valid, out_instr, out_bad
    );
    modport slave (
        input  in_valid, in_group, in_ra_index, in_rb_index, in_rc_index, in_opcode, in_imm_val, out_ready,
        output in_ready, out_valid, out_instr, out_bad
    );
endinterface

// File: rtl/instr_encoder_stream.sv
// instr_encoder_stream: packs decoded fields into Frost32 words, buffers them in a FIFO,
// and replaces illegal records with a flagged NOP.
module instr_encoder_stream #(
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_encoder_stream_if.slave s,
    output logic [CNT_WIDTH-1:0] accepted_count,
    output logic [CNT_WIDTH-1:0] bad_count
);
    localparam int AW = $clog2(DEPTH);
    logic [32:0]          mem_q [DEPTH];
    logic [AW:0]          wr_q, rd_q;
    logic [CNT_WIDTH-1:0] acc_q, bad_q;
    logic                 full, empty, push, pop, legal;
    logic [31:0]          word_d;
    assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    assign empty = wr_q == rd_q;
    assign push  = s.in_valid && !full;
    assign pop   = !empty && s.out_ready;
    assign legal = s.in_group <= 4'd6 &&
                   !(s.in_group == 4'd5 && s.in_imm_val[15:12] != {4{s.in_imm_val[11]}});
    always_comb begin
        word_d = '0;
        case (s.in_group)
            4'd1, 4'd2: word_d = {s.in_group, s.in_ra_index, s.in_rb_index, s.in_opcode, s.in_imm_val};
            4'd5:       word_d = {s.in_group, s.in_ra_index, s.in_rb_index, s.in_rc_index, s.in_opcode, s.in_imm_val[11:0]};
            default:    word_d = {s.in_group, s.in_ra_index, s.in_rb_index, s.in_rc_index, 12'h000, s.in_opcode};
        endcase
        if (!legal) word_d = '0;
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= {!legal, word_d};
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            acc_q <= '0;
            bad_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + (AW+1)'(1);
            if (pop) rd_q <= rd_q + (AW+1)'(1);
            if (push && !(&acc_q)) acc_q <= acc_q + CNT_WIDTH'(1);
            if (push && !legal && !(&bad_q)) bad_q <= bad_q + CNT_WIDTH'(1);
        end
    end
    assign s.in_ready      = !full;
    assign s.out_valid     = !empty;
    assign s.out_instr     = empty ? 32'h0 : mem_q[rd_q[AW-1:0]][31:0];
    assign s.out_bad       = !empty && mem_q[rd_q[AW-1:0]][32];
    assign accepted_count  = acc_q;
    assign bad_count       = bad_q;
endmodule
